md5_arbiter: RTL
================

MD5_ARBITER -- requirements
Module: md5_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: maximum cycles spent waiting for core_done before the job is aborted.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req0 / req1  input  1 each  requester N holds this high while msgN is valid.
REQ-005 msg0 / msg1  input  512 each  single 512-bit pre-padded MD5 block from requester N.
REQ-006 gnt0 / gnt1  output  1 each  one-cycle pulse: msgN captured; requester may drop reqN.
REQ-007 core_message  output  512  block presented to the MD5 core; held stable from START through WAIT.
REQ-008 core_start  output  1  one-cycle start pulse to the core.
REQ-009 core_done  input  1  core completion; sampled only in WAIT.
REQ-010 core_digest  input  128  core result; valid in the cycle core_done=1.
REQ-011 digest_out  output  128  result returned to the requester.
REQ-012 digest_id  output  1  requester index owning digest_out.
REQ-013 digest_err  output  1  1 = job aborted by timeout; digest_out is then 0.
REQ-014 digest_valid / digest_ready  output / input  1 each  result handshake; transfer occurs when both are high.
REQ-015 busy  output  1  high in every state except IDLE.

Function
REQ-016 FSM states SHALL be IDLE, LOAD, START, WAIT and OUT.
REQ-017 IDLE: if any reqN=1, SHALL select the winner, go to LOAD; otherwise stay.
REQ-018 Arbitration SHALL be round-robin: when both requests are high, grant the requester not served last; a single request always wins; last_served updates on each grant.
REQ-019 LOAD: SHALL latch msg[winner] into core_message, pulse gnt[winner] for exactly this cycle, record digest_id, go to START.
REQ-020 START: SHALL assert core_start for exactly one cycle, clear the timeout counter, go to WAIT.
REQ-021 WAIT: SHALL increment the 8-bit-or-wider counter each cycle; on core_done=1, latch core_digest into digest_out, digest_err=0, go to OUT.
REQ-022 WAIT: when the counter reaches TIMEOUT_CYCLES without core_done, SHALL set digest_out=0, digest_err=1, go to OUT.
REQ-023 If core_done and timeout coincide in the same cycle, core_done SHALL win (digest_err=0).
REQ-024 OUT: digest_valid=1 and digest_out/digest_id/digest_err SHALL stay stable until digest_ready=1, then go to IDLE in the following cycle.
REQ-025 Minimum latency, req to digest_valid: 3 cycles + core latency (IDLE->LOAD->START->WAIT->OUT).
REQ-026 core_done outside WAIT SHALL be ignored; requests arriving outside IDLE SHALL wait with no gnt.
REQ-027 A requester that drops reqN before its grant SHALL not be granted; no job is started.

Reset
REQ-028 Asserting reset SHALL immediately force IDLE, including mid-job; the in-flight job is discarded with no digest_valid.
REQ-029 Reset values: gnt0/gnt1=0, core_start=0, core_message=0, digest_out=0, digest_id=0, digest_err=0, digest_valid=0, busy=0, counter=0, last_served=1 (so req0 wins the first tie).

Structure
REQ-030 Shared package md5_pkg SHALL hold the state enumeration, MD5_BLOCK_W=512, MD5_DIGEST_W=128 and the default timeout constant.
REQ-031 The round-robin selector SHALL be a sub-module named md5_rr_pick (inputs req0, req1, last_served; output winner and grant-valid).
REQ-032 The MD5 core itself SHALL be external; md5_arbiter contains no hash datapath.

Verification
REQ-033 req0 alone with msg0 set to the padded block for "abc", core model returns 900150983cd24fb0d6963f7d28e17f72 after 64 cycles -> gnt0 pulse, one core_start, digest_valid with digest_id=0, digest_err=0 and that digest.
REQ-034 req0 and req1 asserted together from reset, twice back-to-back -> grant order 0,1,0,1; exactly four core_start pulses.
REQ-035 Core model never asserts core_done, TIMEOUT_CYCLES=16 -> digest_valid exactly 16 cycles after WAIT entry, with digest_err=1 and digest_out=0.
REQ-036 digest_ready held low 10 cycles while req1 pending -> outputs stable, no gnt1, no core_start until the handshake completes.
REQ-037 reset pulsed during WAIT, then a late core_done -> state IDLE, no digest_valid, and the stray core_done is ignored.
REQ-038 core_done coincident with the timeout cycle -> digest_err=0, digest_out equals core_digest.

Source files
------------

// File: rtl/md5_pkg.sv
// Shared types and constants for the MD5 job arbiter: FSM state encoding,
// block/digest widths and the default core timeout.
package md5_pkg;

  localparam int MD5_BLOCK_W     = 512;
  localparam int MD5_DIGEST_W    = 128;
  localparam int MD5_TIMEOUT_DEF = 255;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_START = 3'd2,
    ST_WAIT  = 3'd3,
    ST_OUT   = 3'd4
  } md5_state_e;

endpackage

// File: rtl/md5_rr_pick.sv
// Two-way round-robin selector, purely combinational: on a tie the requester
// not served last wins; a lone request always wins.
module md5_rr_pick (
  input  logic req0,
  input  logic req1,
  input  logic last_served,
  output logic winner,
  output logic grant_valid
);

  assign grant_valid = req0 | req1;
  assign winner      = (req0 & req1) ? ~last_served : req1;

endmodule

// File: rtl/md5_arbiter.sv
// Shares one external MD5 core between two requesters; req-to-digest_valid is
// 3 cycles plus core latency, and the result is held until digest_ready.
module md5_arbiter
  import md5_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = MD5_TIMEOUT_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req0,
  input  logic                    req1,
  input  logic [MD5_BLOCK_W-1:0]  msg0,
  input  logic [MD5_BLOCK_W-1:0]  msg1,
  output logic                    gnt0,
  output logic                    gnt1,
  output logic [MD5_BLOCK_W-1:0]  core_message,
  output logic                    core_start,
  input  logic                    core_done,
  input  logic [MD5_DIGEST_W-1:0] core_digest,
  output logic [MD5_DIGEST_W-1:0] digest_out,
  output logic                    digest_id,
  output logic                    digest_err,
  output logic                    digest_valid,
  input  logic                    digest_ready,
  output logic                    busy
);

  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  // Last WAIT cycle before abort: the counter has then spent TIMEOUT_CYCLES cycles waiting.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  md5_state_e              state_q, state_d;
  logic                    winner_q, winner_d;
  logic                    last_served_q, last_served_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [MD5_BLOCK_W-1:0]  msg_q, msg_d;
  logic [MD5_DIGEST_W-1:0] dig_q, dig_d;
  logic                    id_q, id_d;
  logic                    err_q, err_d;
  logic                    pick_winner, pick_vld, winner_req;

  md5_rr_pick u_pick (
    .req0        (req0),
    .req1        (req1),
    .last_served (last_served_q),
    .winner      (pick_winner),
    .grant_valid (pick_vld)
  );

  assign winner_req = winner_q ? req1 : req0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      winner_q      <= 1'b0;
      last_served_q <= 1'b1;
      cnt_q         <= '0;
      msg_q         <= '0;
      dig_q         <= '0;
      id_q          <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      winner_q      <= winner_d;
      last_served_q <= last_served_d;
      cnt_q         <= cnt_d;
      msg_q         <= msg_d;
      dig_q         <= dig_d;
      id_q          <= id_d;
      err_q         <= err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    winner_d      = winner_q;
    last_served_d = last_served_q;
    cnt_d         = cnt_q;
    msg_d         = msg_q;
    dig_d         = dig_q;
    id_d          = id_q;
    err_d         = err_q;
    gnt0          = 1'b0;
    gnt1          = 1'b0;
    core_start    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          winner_d = pick_winner;
          state_d  = ST_LOAD;
        end
      end
      ST_LOAD: begin
        // A requester that withdrew before this cycle forfeits the slot.
        if (winner_req) begin
          msg_d         = winner_q ? msg1 : msg0;
          id_d          = winner_q;
          last_served_d = winner_q;
          gnt0          = ~winner_q;
          gnt1          = winner_q;
          state_d       = ST_START;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        core_start = 1'b1;
        cnt_d      = '0;
        state_d    = ST_WAIT;
      end
      ST_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (core_done) begin
          dig_d   = core_digest;
          err_d   = 1'b0;
          state_d = ST_OUT;
        end else if (cnt_q == CNT_LAST) begin
          dig_d   = '0;
          err_d   = 1'b1;
          state_d = ST_OUT;
        end
      end
      ST_OUT: begin
        if (digest_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign core_message = msg_q;
  assign digest_out   = dig_q;
  assign digest_id    = id_q;
  assign digest_err   = err_q;
  assign digest_valid = (state_q == ST_OUT);
  assign busy         = (state_q != ST_IDLE);

endmodule
